// File: rtl/perf_sampler_pkg.sv
// Shared types and helpers for the perf_counters sampler: FSM states, the sample record and the
// counter address computation.
package perf_sampler_pkg;

  localparam int unsigned AddrW    = 5;
  localparam int unsigned MaxDataW = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StEmit,
    StClear
  } state_e;

  typedef struct packed {
    logic [AddrW-1:0]    idx;
    logic [MaxDataW-1:0] data;
    logic                last;
  } sample_t;

  function automatic logic [AddrW-1:0] cnt_addr(input int unsigned first,
                                                input logic [AddrW-1:0] idx);
    return AddrW'(first) + idx;
  endfunction

endpackage

// File: rtl/perf_counter_sampler_if.sv
// Sampler-side bundle: perf_counters CSR access port plus the valid/ready sample stream.
interface perf_counter_sampler_if #(
  parameter int unsigned DATA_W = 64
);
  import perf_sampler_pkg::*;

  logic [AddrW-1:0]  cnt_addr;
  logic              cnt_we;
  logic [DATA_W-1:0] cnt_wdata;
  logic [DATA_W-1:0] cnt_rdata;

  logic              smp_valid;
  logic              smp_ready;
  logic [AddrW-1:0]  smp_idx;
  logic [DATA_W-1:0] smp_data;
  logic              smp_last;

  modport master (
    output cnt_addr, cnt_we, cnt_wdata, smp_valid, smp_idx, smp_data, smp_last,
    input  cnt_rdata, smp_ready
  );

  modport slave (
    input  cnt_addr, cnt_we, cnt_wdata, smp_valid, smp_idx, smp_data, smp_last,
    output cnt_rdata, smp_ready
  );

endinterface

// File: rtl/perf_sample_timer.sv
// Free-running periodic tick source; a zero period parks the timer at 0 with no ticks.
module perf_sample_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  logic [31:0] timer_q, timer_d;

  // A new period takes effect only when the current countdown expires.
  always_comb begin
    timer_d = timer_q;
    tick_o  = 1'b0;
    if (period_i == '0) begin
      timer_d = '0;
    end else if (timer_q == '0) begin
      tick_o  = 1'b1;
      timer_d = period_i - 32'd1;
    end else begin
      timer_d = timer_q - 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/perf_counter_sampler.sv
// Scans a contiguous range of perf counters, optionally clearing each after reading it, and
// streams (index, value) samples out; scans start on request or on a periodic tick.
module perf_counter_sampler
  import perf_sampler_pkg::*;
#(
  parameter int unsigned NUM_CNT   = 6,
  parameter int unsigned FIRST_IDX = 3,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned OVR_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  debug_mode_i,
  input  logic                  start_i,
  input  logic [31:0]           period_i,
  input  logic                  clr_on_rd_i,
  perf_counter_sampler_if.master bus,
  output logic                  busy_o,
  output logic [OVR_W-1:0]      overrun_o
);

  localparam logic [AddrW-1:0] LastIdx = AddrW'(NUM_CNT - 1);

  state_e           state_q, state_d;
  logic [AddrW-1:0] idx_q, idx_d;
  sample_t          smp_q, smp_d;
  logic             clr_q, clr_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  logic             tick;
  logic             trigger;
  logic             is_last;
  logic [AddrW-1:0] addr;
  logic [AddrW-1:0] addr_out;
  logic             we;
  logic             valid;

  perf_sample_timer u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .period_i (period_i),
    .tick_o   (tick)
  );

  assign trigger = start_i | tick;
  assign is_last = (idx_q == LastIdx);
  assign addr    = cnt_addr(FIRST_IDX, idx_q);
  assign busy_o  = (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    smp_d    = smp_q;
    clr_d    = clr_q;
    addr_out = AddrW'(FIRST_IDX);
    we       = 1'b0;
    valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          clr_d   = clr_on_rd_i;
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        addr_out = addr;
        if (!debug_mode_i) begin
          smp_d.idx  = addr;
          smp_d.data = MaxDataW'(bus.cnt_rdata);
          smp_d.last = is_last;
          state_d    = StEmit;
        end
      end
      StEmit: begin
        addr_out = addr;
        valid    = 1'b1;
        if (bus.smp_ready) begin
          if (clr_q) begin
            state_d = StClear;
          end else if (is_last) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      StClear: begin
        addr_out = addr;
        // Write exactly once, only after debug mode is left.
        if (!debug_mode_i) begin
          we = 1'b1;
          if (is_last) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Dropped triggers while busy; start and tick together count once.
  always_comb begin
    ovr_d = ovr_q;
    if (busy_o && trigger && !(&ovr_q)) begin
      ovr_d = ovr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      smp_q   <= '0;
      clr_q   <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      smp_q   <= smp_d;
      clr_q   <= clr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign overrun_o     = ovr_q;
  assign bus.cnt_addr  = addr_out;
  assign bus.cnt_we    = we;
  assign bus.cnt_wdata = '0;
  assign bus.smp_valid = valid;
  assign bus.smp_idx   = valid ? smp_q.idx : '0;
  assign bus.smp_data  = valid ? DATA_W'(smp_q.data) : '0;
  assign bus.smp_last  = valid & smp_q.last;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Bench for perf_counter_sampler: scan table, randomized scans against a counter-array model,
// and hand sequences for debug holds, periodic ticks, overrun saturation and mid-scan reset.
module tb_perf_counter_sampler;

  localparam int unsigned NumCnt   = 6;
  localparam int unsigned FirstIdx = 3;
  localparam int unsigned DataW    = 64;
  localparam int unsigned OvrW     = 4;
  localparam int          OvrMax   = (1 << OvrW) - 1;

  typedef struct {
    logic [63:0] base;
    bit          reload;
    bit          clr;
    int          stall_at;
    int          stall_len;
    int          pct;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            debug;
  logic            start;
  logic [31:0]     period;
  logic            clr_on_rd;
  logic            ready;
  logic            busy;
  logic [OvrW-1:0] overrun;

  logic [DataW-1:0] mem [32];
  int               wr_cnt [32];
  logic             load_en;
  logic [DataW-1:0] load_base;
  logic [63:0]      model_mem [32];

  int checks = 0;
  int errors = 0;

  perf_counter_sampler_if #(.DATA_W(DataW)) bus ();

  perf_counter_sampler #(
    .NUM_CNT   (NumCnt),
    .FIRST_IDX (FirstIdx),
    .DATA_W    (DataW),
    .OVR_W     (OvrW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .debug_mode_i (debug),
    .start_i      (start),
    .period_i     (period),
    .clr_on_rd_i  (clr_on_rd),
    .bus          (bus),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  // Counter array seen by the sampler.
  assign bus.cnt_rdata = mem[bus.cnt_addr];
  assign bus.smp_ready = ready;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= load_base + 64'(i);
    end else if (bus.cnt_we) begin
      mem[bus.cnt_addr]    <= bus.cnt_wdata;
      wr_cnt[bus.cnt_addr] <= wr_cnt[bus.cnt_addr] + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [63:0] base);
    @(negedge clk);
    load_en   = 1'b1;
    load_base = base;
    @(negedge clk);
    load_en = 1'b0;
    for (int i = 0; i < 32; i++) model_mem[i] = base + 64'(i);
  endtask

  task automatic chk_mem(input int snap [32], input int exp_wr);
    for (int i = 0; i < 32; i++) begin
      chk("counter_value", mem[i], model_mem[i]);
      if (i >= FirstIdx && i < FirstIdx + NumCnt) chk("writes_per_counter", wr_cnt[i] - snap[i], exp_wr);
      else chk("writes_outside_range", wr_cnt[i] - snap[i], 0);
    end
  endtask

  task automatic run_scan(input bit clr, input int stall_at, input int stall_len, input int pct,
                          output logic [63:0] first_d, output logic [63:0] last_d);
    int k      = 0;
    int cyc    = 0;
    int stalls = 0;
    bit hs_prev = 1'b0;
    int snap [32];
    first_d = '0;
    last_d  = '0;
    snap    = wr_cnt;
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    clr_on_rd = clr;
    start     = 1'b1;
    ready     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_valid_in_read", bus.smp_valid, 0);
    @(negedge clk);
    chk("first_valid_latency", bus.smp_valid, 1);
    while (k < NumCnt && cyc < 300) begin
      chk("we_only_after_read", bus.cnt_we, clr && hs_prev);
      if (bus.cnt_we) chk("clear_addr", bus.cnt_addr, 64'(FirstIdx + k - 1));
      hs_prev = 1'b0;
      if (bus.smp_valid) begin
        chk("smp_idx", bus.smp_idx, 64'(FirstIdx + k));
        chk("smp_data", bus.smp_data, model_mem[FirstIdx + k]);
        chk("smp_last", bus.smp_last, k == NumCnt - 1);
        chk("addr_held", bus.cnt_addr, 64'(FirstIdx + k));
        if (k == 0) first_d = bus.smp_data;
        if (k == NumCnt - 1) last_d = bus.smp_data;
        if (k == stall_at && stalls < stall_len) begin
          ready = 1'b0;
          stalls++;
        end else begin
          ready = (int'($urandom_range(99)) < pct);
        end
        if (ready) begin
          k++;
          hs_prev = 1'b1;
        end
      end else begin
        ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
    end
    if (k < NumCnt) chk("scan_timeout", k, NumCnt);
    ready = 1'b0;
    if (clr) begin
      chk("last_clear_we", bus.cnt_we, 1);
      chk("last_clear_addr", bus.cnt_addr, 64'(FirstIdx + NumCnt - 1));
      chk("busy_in_last_clear", busy, 1);
      @(negedge clk);
    end
    chk("busy_fall", busy, 0);
    chk("we_after_scan", bus.cnt_we, 0);
    if (clr) for (int i = 0; i < NumCnt; i++) model_mem[FirstIdx + i] = '0;
    chk_mem(snap, clr ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [5];
    logic [63:0] f, l;
    int          snap [32];
    int          t;
    int          rises [$];
    bit          busy_prev;
    int          exp_ovr;

    vecs[0] = '{base: 64'd7, reload: 1, clr: 0, stall_at: -1, stall_len: 0, pct: 100,
                exp_first: 64'd10, exp_last: 64'd15};
    vecs[1] = '{base: 64'd100, reload: 1, clr: 1, stall_at: -1, stall_len: 0, pct: 100,
                exp_first: 64'd103, exp_last: 64'd108};
    vecs[2] = '{base: 64'd7, reload: 1, clr: 0, stall_at: 2, stall_len: 5, pct: 100,
                exp_first: 64'd10, exp_last: 64'd15};
    vecs[3] = '{base: 64'h1000, reload: 1, clr: 1, stall_at: 0, stall_len: 3, pct: 100,
                exp_first: 64'h1003, exp_last: 64'h1008};
    vecs[4] = '{base: 64'd0, reload: 0, clr: 0, stall_at: -1, stall_len: 0, pct: 100,
                exp_first: 64'd0, exp_last: 64'd0};

    rst = 1'b1; debug = 1'b0; start = 1'b0; period = '0; clr_on_rd = 1'b0; ready = 1'b0;
    load_en = 1'b0; load_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.smp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", bus.cnt_addr, 64'(FirstIdx));
    chk("rst_we", bus.cnt_we, 0);
    chk("rst_wdata", bus.cnt_wdata, 0);
    chk("rst_idx", bus.smp_idx, 0);
    chk("rst_data", bus.smp_data, 0);
    chk("rst_last", bus.smp_last, 0);
    rst = 1'b0;

    // Scan table.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].reload) load(vecs[v].base);
      run_scan(vecs[v].clr, vecs[v].stall_at, vecs[v].stall_len, vecs[v].pct, f, l);
      chk("vec_first_data", f, vecs[v].exp_first);
      chk("vec_last_data", l, vecs[v].exp_last);
    end

    // Randomized scans against the counter-array model.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(3) != 0) load({$urandom, $urandom});
      run_scan(1'($urandom_range(1)), int'($urandom_range(NumCnt - 1)), int'($urandom_range(4)),
               int'($urandom_range(100, 30)), f, l);
    end

    // Trigger in IDLE during debug: accepted, waits in READ.
    load(64'd200);
    @(negedge clk);
    clr_on_rd = 1'b0; debug = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dbg_idle_accept", busy, 1);
    repeat (3) begin
      chk("dbg_read_hold_valid", bus.smp_valid, 0);
      chk("dbg_read_hold_addr", bus.cnt_addr, 64'(FirstIdx));
      @(negedge clk);
    end
    debug = 1'b0;
    @(negedge clk);
    chk("dbg_read_release", bus.smp_valid, 1);
    chk("dbg_read_data", bus.smp_data, 64'd203);
    ready = 1'b1;
    t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    chk("dbg_idle_scan_done", busy, 0);
    ready = 1'b0;

    // Debug during CLEAR: write held, then issued once.
    load(64'd50);
    snap = wr_cnt;
    @(negedge clk);
    clr_on_rd = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!bus.smp_valid && t < 20) begin @(negedge clk); t++; end
    chk("dbg_clr_first_valid", bus.smp_valid, 1);
    ready = 1'b1; debug = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (3) begin
      chk("dbg_clr_we_held", bus.cnt_we, 0);
      chk("dbg_clr_busy", busy, 1);
      chk("dbg_clr_no_valid", bus.smp_valid, 0);
      @(negedge clk);
    end
    chk("dbg_clr_no_early_write", wr_cnt[FirstIdx] - snap[FirstIdx], 0);
    debug = 1'b0;
    #1;
    chk("dbg_clr_release_we", bus.cnt_we, 1);
    chk("dbg_clr_release_addr", bus.cnt_addr, 64'(FirstIdx));
    ready = 1'b1;
    t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    chk("dbg_clr_scan_done", busy, 0);
    ready = 1'b0;
    for (int i = 0; i < NumCnt; i++) model_mem[FirstIdx + i] = '0;
    chk_mem(snap, 1);

    // Periodic scans every 20 cycles.
    @(negedge clk);
    clr_on_rd = 1'b0; ready = 1'b1; period = 32'd20;
    busy_prev = 1'b0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (busy && !busy_prev) rises.push_back(n);
      busy_prev = busy;
    end
    period = '0;
    chk("period_scan_count", rises.size() >= 3, 1);
    if (rises.size() >= 3) begin
      chk("period_gap_1", rises[1] - rises[0], 20);
      chk("period_gap_2", rises[2] - rises[1], 20);
    end
    t = 0;
    while (busy && t < 50) begin @(negedge clk); t++; end
    chk("period_no_overrun", overrun, 0);

    // Period 5 with the sink stalled: every tick (and start) while busy is dropped.
    @(negedge clk);
    rst = 1'b1; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; period = 32'd5;
    @(negedge clk);
    chk("tick_scan_started", busy, 1);
    exp_ovr = 0;
    for (int m = 1; m <= 100; m++) begin
      start = (m == 7 || m == 10);
      @(negedge clk);
      if ((m % 5 == 0 || m == 7) && exp_ovr < OvrMax) exp_ovr++;
      chk("overrun_count", overrun, 64'(exp_ovr));
    end
    start = 1'b0;
    chk("overrun_saturated", overrun, 64'(OvrMax));

    // Reset while in EMIT.
    snap = wr_cnt;
    chk("pre_reset_valid", bus.smp_valid, 1);
    rst = 1'b1; period = '0;
    @(negedge clk);
    chk("mid_rst_valid", bus.smp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_we", bus.cnt_we, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_clear", wr_cnt[FirstIdx] - snap[FirstIdx], 0);
    chk("mid_rst_stays_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
